scanline_mixer: RTL and testbench

SCANLINE_MIXER -- requirements
Module: scanline_mixer

---
 rtl/scanline_mixer_pkg.sv | 26 ++
 rtl/scanline_mixer_if.sv | 29 ++
 rtl/scanline_dim.sv | 23 ++
 rtl/scanline_mixer.sv | 138 +++++++++++++
 tb/tb_scanline_mixer.sv | 340 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/scanline_mixer_pkg.sv
// Shared types and helpers for the scanline mixer: dimming levels and the
// colour-depth expansion used by the first pipeline stage.
package scanline_mixer_pkg;

  typedef enum logic [1:0] {
    SL_NONE = 2'd0,
    SL_75   = 2'd1,
    SL_50   = 2'd2,
    SL_25   = 2'd3
  } sl_level_e;

  // Repeat the low 'depth' bits of v MSB-first until 8 bits are filled.
  function automatic logic [7:0] expand8(input logic [7:0] v, input int depth);
    logic [7:0] r;
    logic [2:0] idx_o;
    logic [2:0] idx_i;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      idx_o    = 3'(7 - i);
      idx_i    = 3'(depth - 1 - (i % depth));
      r[idx_o] = v[idx_i];
    end
    return r;
  endfunction

endpackage

// File: rtl/scanline_mixer_if.sv
// Video bus between a timing/colour source and the mixer, plus the processed
// VGA-side outputs returned by the mixer.
interface scanline_mixer_if #(
  parameter int IN_DEPTH = 8
);
  logic [IN_DEPTH-1:0] R;
  logic [IN_DEPTH-1:0] G;
  logic [IN_DEPTH-1:0] B;
  logic                HSync;
  logic                VSync;
  logic                HBlank;
  logic                VBlank;
  logic [7:0]          VGA_R;
  logic [7:0]          VGA_G;
  logic [7:0]          VGA_B;
  logic                VGA_HS;
  logic                VGA_VS;
  logic                VGA_DE;

  modport master (
    output R, G, B, HSync, VSync, HBlank, VBlank,
    input  VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, VGA_DE
  );

  modport slave (
    input  R, G, B, HSync, VSync, HBlank, VBlank,
    output VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, VGA_DE
  );
endinterface

// File: rtl/scanline_dim.sv
// Combinational scanline dimmer for one 8-bit colour component.
module scanline_dim
  import scanline_mixer_pkg::*;
(
  input  logic [7:0] pix_i,
  input  sl_level_e  level_i,
  input  logic       en_i,
  output logic [7:0] pix_o
);

  always_comb begin
    pix_o = pix_i;
    if (en_i) begin
      unique case (level_i)
        SL_NONE: pix_o = pix_i;
        SL_75:   pix_o = (pix_i >> 1) + (pix_i >> 2);
        SL_50:   pix_o = pix_i >> 1;
        SL_25:   pix_o = pix_i >> 2;
      endcase
    end
  end

endmodule

// File: rtl/scanline_mixer.sv
// Two-stage scanline mixer: colour expansion, then dimming/blanking with
// sync-edge tracking of line parity, data enable and active line width.
module scanline_mixer
  import scanline_mixer_pkg::*;
#(
  parameter int IN_DEPTH = 8,
  parameter int CNT_W    = 12
) (
  input  logic             clk_sys,
  input  logic             reset_n,
  input  logic             ce_pix,
  input  logic [1:0]       scanlines,
  input  logic             sl_phase,
  input  logic             mono,
  output logic             ce_pix_out,
  output logic             line_parity,
  output logic [CNT_W-1:0] hact_w,
  scanline_mixer_if.slave  vid
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // ce_pix qualifies every stage: registers move only on clk_sys edges with
  // ce_pix=1; there is no back-pressure, so each enable carries one pixel.
  logic [7:0] r_in, g_in, b_in;
  logic [7:0] r1_q, g1_q, b1_q;
  logic       hs1_q, vs1_q, hde1_q, vde1_q, vld1_q;
  logic       hist_vld_q, hs_prev_q, vs_prev_q, hde_prev_q;
  logic       par_q, par_d, de_q, de_d, meas_q, meas_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, hact_q, hact_d;
  logic       hs_fall, vs_fall, hde_rise, hde_fall, dim_en;
  logic [7:0] r_sel, b_sel, r_dim, g_dim, b_dim;
  logic [7:0] vga_r_q, vga_g_q, vga_b_q;
  logic       vga_hs_q, vga_vs_q, ce_out_q;

  always_comb begin
    r_in = '0;
    g_in = '0;
    b_in = '0;
    r_in[IN_DEPTH-1:0] = vid.R;
    g_in[IN_DEPTH-1:0] = vid.G;
    b_in[IN_DEPTH-1:0] = vid.B;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r1_q <= '0; g1_q <= '0; b1_q <= '0;
      hs1_q <= 1'b0; vs1_q <= 1'b0; hde1_q <= 1'b0; vde1_q <= 1'b0;
      vld1_q <= 1'b0;
    end else if (ce_pix) begin
      r1_q   <= expand8(r_in, IN_DEPTH);
      g1_q   <= expand8(g_in, IN_DEPTH);
      b1_q   <= expand8(b_in, IN_DEPTH);
      hs1_q  <= vid.HSync;
      vs1_q  <= vid.VSync;
      hde1_q <= ~vid.HBlank;
      vde1_q <= ~vid.VBlank;
      vld1_q <= 1'b1;
    end
  end

  // Edges need two real stage-1 samples, so a reset in mid-line cannot fake
  // an hde rise from the cleared history.
  always_comb begin
    hs_fall  = hist_vld_q &  hs_prev_q  & ~hs1_q;
    vs_fall  = hist_vld_q &  vs_prev_q  & ~vs1_q;
    hde_rise = hist_vld_q & ~hde_prev_q &  hde1_q;
    hde_fall = hist_vld_q &  hde_prev_q & ~hde1_q;
  end

  always_comb begin
    par_d  = par_q;
    de_d   = de_q;
    cnt_d  = cnt_q;
    meas_d = meas_q;
    hact_d = hact_q;
    if (vs_fall)      par_d = sl_phase;
    else if (hs_fall) par_d = ~par_q;
    if (hde_rise)      de_d = vde1_q;
    else if (hde_fall) de_d = 1'b0;
    if (hde_rise) begin
      cnt_d  = CNT_W'(1);
      meas_d = 1'b1;
    end else if (hde1_q && cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 1'b1;
    end
    if (hde_fall && meas_q) hact_d = cnt_q;
  end

  assign dim_en = par_q & (scanlines != 2'd0);
  assign r_sel  = mono ? g1_q : r1_q;
  assign b_sel  = mono ? g1_q : b1_q;

  scanline_dim u_dim_r (.pix_i(r_sel), .level_i(sl_level_e'(scanlines)), .en_i(dim_en), .pix_o(r_dim));
  scanline_dim u_dim_g (.pix_i(g1_q),  .level_i(sl_level_e'(scanlines)), .en_i(dim_en), .pix_o(g_dim));
  scanline_dim u_dim_b (.pix_i(b_sel), .level_i(sl_level_e'(scanlines)), .en_i(dim_en), .pix_o(b_dim));

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      hist_vld_q <= 1'b0; hs_prev_q <= 1'b0; vs_prev_q <= 1'b0; hde_prev_q <= 1'b0;
      par_q <= 1'b0; de_q <= 1'b0; meas_q <= 1'b0;
      cnt_q <= '0; hact_q <= '0;
      vga_r_q <= '0; vga_g_q <= '0; vga_b_q <= '0;
      vga_hs_q <= 1'b0; vga_vs_q <= 1'b0;
    end else if (ce_pix) begin
      hist_vld_q <= vld1_q;
      hs_prev_q  <= hs1_q;
      vs_prev_q  <= vs1_q;
      hde_prev_q <= hde1_q;
      par_q      <= par_d;
      de_q       <= de_d;
      meas_q     <= meas_d;
      cnt_q      <= cnt_d;
      hact_q     <= hact_d;
      vga_r_q    <= de_d ? r_dim : 8'h00;
      vga_g_q    <= de_d ? g_dim : 8'h00;
      vga_b_q    <= de_d ? b_dim : 8'h00;
      vga_hs_q   <= hs1_q;
      vga_vs_q   <= vs1_q;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) ce_out_q <= 1'b0;
    else          ce_out_q <= ce_pix;
  end

  assign vid.VGA_R   = vga_r_q;
  assign vid.VGA_G   = vga_g_q;
  assign vid.VGA_B   = vga_b_q;
  assign vid.VGA_HS  = vga_hs_q;
  assign vid.VGA_VS  = vga_vs_q;
  assign vid.VGA_DE  = de_q;
  assign ce_pix_out  = ce_out_q;
  assign line_parity = par_q;
  assign hact_w      = hact_q;

endmodule

// File: tb/tb_scanline_mixer.sv
// Randomised scoreboard bench for scanline_mixer: an 8-bit/12-bit instance and
// a 3-bit/9-bit instance share one timing stream and one reference model.
module tb_scanline_mixer;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic        ce_pix = 1'b0;
  logic [1:0]  scanlines = 2'd0;
  logic        sl_phase = 1'b0;
  logic        mono = 1'b0;
  logic        ce_out_a, ce_out_b, par_a, par_b;
  logic [11:0] hact_a;
  logic [8:0]  hact_b;
  int          total = 0;
  int          bad = 0;

  always #5 clk_sys = ~clk_sys;

  scanline_mixer_if #(.IN_DEPTH(8)) vid_a ();
  scanline_mixer_if #(.IN_DEPTH(3)) vid_b ();

  assign vid_b.R      = vid_a.R[7:5];
  assign vid_b.G      = vid_a.G[7:5];
  assign vid_b.B      = vid_a.B[7:5];
  assign vid_b.HSync  = vid_a.HSync;
  assign vid_b.VSync  = vid_a.VSync;
  assign vid_b.HBlank = vid_a.HBlank;
  assign vid_b.VBlank = vid_a.VBlank;

  scanline_mixer #(.IN_DEPTH(8), .CNT_W(12)) dut_a (
    .clk_sys(clk_sys), .reset_n(reset_n), .ce_pix(ce_pix), .scanlines(scanlines),
    .sl_phase(sl_phase), .mono(mono), .ce_pix_out(ce_out_a), .line_parity(par_a),
    .hact_w(hact_a), .vid(vid_a.slave));

  scanline_mixer #(.IN_DEPTH(3), .CNT_W(9)) dut_b (
    .clk_sys(clk_sys), .reset_n(reset_n), .ce_pix(ce_pix), .scanlines(scanlines),
    .sl_phase(sl_phase), .mono(mono), .ce_pix_out(ce_out_b), .line_parity(par_b),
    .hact_w(hact_b), .vid(vid_b.slave));

  typedef struct packed {
    logic [7:0] r, g, b;
    logic hs, vs, hde, vde;
  } smp_t;

  typedef struct packed {
    logic [7:0] ra, ga, ba, rb, gb, bb;
    logic hs, vs, de, par;
    logic [11:0] ha;
    logic [8:0] hb;
  } out_t;

  out_t exp_q[$];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Reference: fill 8 bits by concatenating copies of v, keep the top 8.
  function automatic logic [7:0] expand(input int v, input int depth);
    int acc = 0;
    int bits = 0;
    while (bits < 8) begin
      acc = (acc << depth) | v;
      bits += depth;
    end
    return 8'(acc >> (bits - 8));
  endfunction

  function automatic logic [7:0] dim(input logic [7:0] x, input int lvl);
    case (lvl)
      1: return 8'((x >> 1) + (x >> 2));
      2: return x >> 1;
      3: return x >> 2;
      default: return x;
    endcase
  endfunction

  // Model state: the pixel currently in the first stage and the one before it.
  smp_t m_cur, m_prev;
  int   m_have, m_cnt_a, m_cnt_b;
  logic m_de, m_par, m_meas;
  logic [11:0] m_ha;
  logic [8:0]  m_hb;

  task automatic model_reset();
    m_cur = '0; m_prev = '0; m_have = 0; m_cnt_a = 0; m_cnt_b = 0;
    m_de = 1'b0; m_par = 1'b0; m_meas = 1'b0; m_ha = '0; m_hb = '0;
    exp_q.delete();
  endtask

  task automatic model_step(input smp_t s);
    out_t e;
    logic ok, hf, vf, hr, hd;
    logic [7:0] rs, bs;
    int lvl;
    ok = (m_have >= 2);
    hf = ok && m_prev.hs && !m_cur.hs;
    vf = ok && m_prev.vs && !m_cur.vs;
    hr = ok && !m_prev.hde && m_cur.hde;
    hd = ok && m_prev.hde && !m_cur.hde;
    if (hr) m_de = m_cur.vde;
    else if (hd) m_de = 1'b0;
    lvl = m_par ? int'(scanlines) : 0;
    rs = mono ? m_cur.g : m_cur.r;
    bs = mono ? m_cur.g : m_cur.b;
    e.ra = m_de ? dim(rs, lvl) : 8'h00;
    e.ga = m_de ? dim(m_cur.g, lvl) : 8'h00;
    e.ba = m_de ? dim(bs, lvl) : 8'h00;
    e.rb = m_de ? dim(expand(int'(rs >> 5), 3), lvl) : 8'h00;
    e.gb = m_de ? dim(expand(int'(m_cur.g >> 5), 3), lvl) : 8'h00;
    e.bb = m_de ? dim(expand(int'(bs >> 5), 3), lvl) : 8'h00;
    e.hs = m_cur.hs;
    e.vs = m_cur.vs;
    e.de = m_de;
    if (vf) m_par = sl_phase;
    else if (hf) m_par = ~m_par;
    e.par = m_par;
    if (hr) begin
      m_cnt_a = 1; m_cnt_b = 1; m_meas = 1'b1;
    end else if (m_cur.hde) begin
      if (m_cnt_a < 4095) m_cnt_a++;
      if (m_cnt_b < 511) m_cnt_b++;
    end
    if (hd && m_meas) begin
      m_ha = 12'(m_cnt_a);
      m_hb = 9'(m_cnt_b);
    end
    e.ha = m_ha;
    e.hb = m_hb;
    exp_q.push_back(e);
    m_prev = m_cur;
    m_cur  = s;
    if (m_have < 2) m_have++;
  endtask

  function automatic out_t actual();
    out_t a;
    a.ra = vid_a.VGA_R; a.ga = vid_a.VGA_G; a.ba = vid_a.VGA_B;
    a.rb = vid_b.VGA_R; a.gb = vid_b.VGA_G; a.bb = vid_b.VGA_B;
    a.hs = vid_a.VGA_HS; a.vs = vid_a.VGA_VS; a.de = vid_a.VGA_DE; a.par = par_a;
    a.ha = hact_a; a.hb = hact_b;
    return a;
  endfunction

  // Driver
  int g_gap_min = 0;
  int g_gap_max = 0;
  bit g_fix = 0;
  bit g_rnd_ctl = 0;

  task automatic px(input logic hs, input logic vs, input logic hb, input logic vb,
                    input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    smp_t s;
    int gap;
    gap = $urandom_range(g_gap_max, g_gap_min);
    repeat (gap) begin
      @(negedge clk_sys);
      ce_pix = 1'b0;
      vid_a.R = 8'($urandom); vid_a.G = 8'($urandom); vid_a.B = 8'($urandom);
      vid_a.HSync = 1'($urandom); vid_a.VSync = 1'($urandom);
      vid_a.HBlank = 1'($urandom); vid_a.VBlank = 1'($urandom);
    end
    @(negedge clk_sys);
    if (g_rnd_ctl && $urandom_range(0, 5) == 0) begin
      scanlines = 2'($urandom); mono = 1'($urandom); sl_phase = 1'($urandom);
    end
    ce_pix = 1'b1;
    vid_a.R = r; vid_a.G = g; vid_a.B = b;
    vid_a.HSync = hs; vid_a.VSync = vs; vid_a.HBlank = hb; vid_a.VBlank = vb;
    s.r = r; s.g = g; s.b = b; s.hs = hs; s.vs = vs; s.hde = ~hb; s.vde = ~vb;
    model_step(s);
  endtask

  task automatic blank(input int n, input logic hs, input logic vs, input logic vb);
    repeat (n) px(hs, vs, 1'b1, vb, 8'($urandom), 8'($urandom), 8'($urandom));
  endtask

  task automatic active(input int n, input logic vb);
    repeat (n) begin
      if (g_fix) px(1'b0, 1'b0, 1'b0, vb, 8'hA0, 8'hFF, 8'($urandom));
      else       px(1'b0, 1'b0, 1'b0, vb, 8'($urandom), 8'($urandom), 8'($urandom));
    end
  endtask

  // One line: porch, hsync pulse (optionally with vsync), porch, active, porch.
  task automatic line(input int act, input logic vb, input logic with_vs);
    blank(2, 1'b0, 1'b0, vb);
    blank(3, 1'b1, with_vs, vb);
    blank(2, 1'b0, 1'b0, vb);
    active(act, vb);
    blank(2, 1'b0, 1'b0, vb);
  endtask

  task automatic frame(input int nvb, input int nact, input int act);
    blank(2, 1'b0, 1'b1, 1'b1);
    blank(2, 1'b0, 1'b0, 1'b1);
    repeat (nvb) line(act, 1'b1, 1'b0);
    repeat (nact) line(act, 1'b0, 1'b0);
  endtask

  task automatic check_all_zero(input string nm);
    chk({nm, "_vga"}, actual(), '0);
    chk({nm, "_par_b"}, par_b, 1'b0);
    chk({nm, "_ce_a"}, ce_out_a, 1'b0);
    chk({nm, "_ce_b"}, ce_out_b, 1'b0);
  endtask

  // Monitor: pops one expectation per enable, otherwise outputs must hold.
  out_t last;
  int   de_run = 0;
  int   de_last_run = 0;

  initial begin
    out_t act, e;
    logic ce_s;
    last = '0;
    forever begin
      @(posedge clk_sys);
      ce_s = ce_pix;
      #1;
      if (!reset_n) begin
        last = '0;
        de_run = 0;
        continue;
      end
      chk("ce_out_a", ce_out_a, ce_s);
      chk("ce_out_b", ce_out_b, ce_s);
      act = actual();
      if (ce_s) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL underflow: output enable with no expectation queued");
        end else begin
          e = exp_q.pop_front();
          chk("rgb_a", {act.ra, act.ga, act.ba}, {e.ra, e.ga, e.ba});
          chk("rgb_b", {act.rb, act.gb, act.bb}, {e.rb, e.gb, e.bb});
          chk("hs_vs_de", {act.hs, act.vs, act.de}, {e.hs, e.vs, e.de});
          chk("parity_a", act.par, e.par);
          chk("parity_b", par_b, e.par);
          chk("hact_a", act.ha, e.ha);
          chk("hact_b", act.hb, e.hb);
        end
        if (act.de) de_run++;
        else if (de_run > 0) begin
          de_last_run = de_run;
          de_run = 0;
        end
      end else begin
        chk("hold", act, last);
      end
      last = act;
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: time limit reached, total=%0d", total);
    $fatal(1, "watchdog");
  end

  initial begin
    vid_a.R = '0; vid_a.G = '0; vid_a.B = '0;
    vid_a.HSync = 1'b0; vid_a.VSync = 1'b0; vid_a.HBlank = 1'b1; vid_a.VBlank = 1'b1;
    model_reset();
    repeat (3) @(negedge clk_sys);
    check_all_zero("reset");
    reset_n = 1'b1;

    // Directed colour and dimming: R=A0 (3-bit 101 -> B6), G=FF.
    g_fix = 1;
    sl_phase = 1'b1;
    frame(1, 2, 16);
    for (int lvl = 1; lvl < 4; lvl++) begin
      scanlines = 2'(lvl);
      line(16, 1'b0, 1'b0);
      line(16, 1'b0, 1'b0);
    end
    mono = 1'b1;
    line(16, 1'b0, 1'b0);
    line(16, 1'b0, 1'b0);
    mono = 1'b0;
    scanlines = 2'd2;
    line(16, 1'b0, 1'b1);
    @(posedge clk_sys); #2;
    chk("par_hs_vs_same", par_a, 1'b1);
    g_fix = 0;

    // Full-width line with and without vertical blank.
    g_gap_max = 1;
    line(320, 1'b0, 1'b0);
    @(posedge clk_sys); #2;
    chk("hact_320", hact_a, 12'd320);
    chk("de_run_320", de_last_run, 320);
    line(320, 1'b1, 1'b0);

    // Reset in the middle of an active line.
    g_gap_max = 0;
    blank(3, 1'b0, 1'b0, 1'b0);
    active(10, 1'b0);
    @(negedge clk_sys);
    ce_pix = 1'b0;
    #2 reset_n = 1'b0;
    #1 check_all_zero("midline_reset");
    repeat (2) @(negedge clk_sys);
    reset_n = 1'b1;
    model_reset();
    active(10, 1'b0);
    blank(3, 1'b0, 1'b0, 1'b0);
    line(20, 1'b0, 1'b0);

    // One enable in four.
    g_gap_min = 3; g_gap_max = 3;
    frame(1, 3, 12);

    // Random timing, colours and control changes.
    g_gap_min = 0; g_gap_max = 2;
    g_rnd_ctl = 1;
    for (int k = 0; k < 3; k++) frame($urandom_range(0, 2), $urandom_range(3, 6), $urandom_range(4, 30));
    g_rnd_ctl = 0;

    // Width counter saturation in the 9-bit instance.
    g_gap_min = 0; g_gap_max = 0;
    line(600, 1'b0, 1'b0);
    @(posedge clk_sys); #2;
    chk("hact_600_a", hact_a, 12'd600);
    chk("hact_sat_b", hact_b, 9'd511);

    @(negedge clk_sys);
    ce_pix = 1'b0;
    repeat (4) @(negedge clk_sys);
    chk("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
